// File: rtl/si_mul_sched.sv
// rtl/si_mul_sched.sv - round-robin scheduler sharing one multi-cycle multiplier among NREQ requesters
module si_mul_sched #(
   parameter int REG_DW  = 32,
   parameter int NREQ    = 2,
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 4
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [NREQ-1:0]        req_valid_i,
   output logic [NREQ-1:0]        req_ready_o,
   input  logic [NREQ*REG_DW-1:0] req_op1_i,
   input  logic [NREQ*REG_DW-1:0] req_op2_i,
   output logic [NREQ-1:0]        rsp_valid_o,
   input  logic [NREQ-1:0]        rsp_ready_i,
   output logic [REG_DW-1:0]      rsp_result_o,
   output logic                   rsp_err_o,
   output logic                   mul_start_o,
   output logic [REG_DW-1:0]      mul_op1_o,
   output logic [REG_DW-1:0]      mul_op2_o,
   input  logic                   mul_done_i,
   input  logic [REG_DW-1:0]      mul_result_i,
   output logic                   busy_o
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;

   typedef enum logic [1:0] {S_IDLE, S_START, S_WAIT, S_RESP} state_t;

   state_t            state_q;
   logic [IW-1:0]     rr_q;
   logic [IW-1:0]     owner_q;
   logic [REG_DW-1:0] op1_q;
   logic [REG_DW-1:0] op2_q;
   logic [REG_DW-1:0] result_q;
   logic              err_q;
   logic [CNT_W-1:0]  wd_cnt_q;
   logic              mul_start_q;
   logic              busy_q;
   logic [NREQ-1:0]   rsp_valid_q;

   logic              grant_any_d;
   logic [IW-1:0]     grant_idx_d;
   logic [NREQ-1:0]   owner_oh_d;
   logic [IW-1:0]     rr_d;
   logic [CNT_W-1:0]  wd_cnt_d;
   int                scan_j;

   // Scan from the highest offset down so the requester closest to rr_q wins last.
   always_comb begin
      grant_any_d = 1'b0;
      grant_idx_d = '0;
      scan_j      = 0;
      for (int i = NREQ - 1; i >= 0; i--) begin
         scan_j = int'(rr_q) + i;
         if (scan_j >= NREQ) scan_j = scan_j - NREQ;
         if (req_valid_i[scan_j]) begin
            grant_any_d = 1'b1;
            grant_idx_d = IW'(scan_j);
         end
      end
      req_ready_o = '0;
      if (state_q == S_IDLE && grant_any_d) req_ready_o[grant_idx_d] = 1'b1;
   end

   assign owner_oh_d = {{(NREQ-1){1'b0}}, 1'b1} << owner_q;
   assign rr_d       = (owner_q == IW'(NREQ - 1)) ? '0 : owner_q + IW'(1);
   assign wd_cnt_d   = wd_cnt_q + CNT_W'(1);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= S_IDLE;
         rr_q        <= '0;
         owner_q     <= '0;
         op1_q       <= '0;
         op2_q       <= '0;
         result_q    <= '0;
         err_q       <= 1'b0;
         wd_cnt_q    <= '0;
         mul_start_q <= 1'b0;
         busy_q      <= 1'b0;
         rsp_valid_q <= '0;
      end else begin
         mul_start_q <= 1'b0;
         case (state_q)
            S_IDLE: begin
               if (grant_any_d) begin
                  state_q     <= S_START;
                  owner_q     <= grant_idx_d;
                  op1_q       <= req_op1_i[int'(grant_idx_d)*REG_DW +: REG_DW];
                  op2_q       <= req_op2_i[int'(grant_idx_d)*REG_DW +: REG_DW];
                  mul_start_q <= 1'b1;
                  busy_q      <= 1'b1;
               end
            end
            S_START: begin
               state_q  <= S_WAIT;
               wd_cnt_q <= '0;
            end
            S_WAIT: begin
               // A done arriving on the watchdog's last cycle still counts as success.
               if (mul_done_i) begin
                  state_q     <= S_RESP;
                  result_q    <= mul_result_i;
                  err_q       <= 1'b0;
                  rsp_valid_q <= owner_oh_d;
               end else if (wd_cnt_q == CNT_W'(TIMEOUT - 1)) begin
                  state_q     <= S_RESP;
                  result_q    <= '0;
                  err_q       <= 1'b1;
                  rsp_valid_q <= owner_oh_d;
               end else begin
                  wd_cnt_q <= wd_cnt_d;
               end
            end
            S_RESP: begin
               if (rsp_ready_i[owner_q]) begin
                  state_q     <= S_IDLE;
                  rr_q        <= rr_d;
                  result_q    <= '0;
                  err_q       <= 1'b0;
                  rsp_valid_q <= '0;
                  busy_q      <= 1'b0;
               end
            end
            default: state_q <= S_IDLE;
         endcase
      end
   end

   assign rsp_valid_o  = rsp_valid_q;
   assign rsp_result_o = result_q;
   assign rsp_err_o    = err_q;
   assign mul_start_o  = mul_start_q;
   assign mul_op1_o    = op1_q;
   assign mul_op2_o    = op2_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_si_mul_sched.sv
// tb/tb_si_mul_sched.sv - randomized bench for si_mul_sched against a job-level timestamp model
module tb_si_mul_sched;
   localparam int DW = 32;
   localparam int NR = 2;
   localparam int TO = 15;

   logic clk = 1'b0;
   logic rst = 1'b1;
   always #5 clk = ~clk;

   logic [NR-1:0]    req_valid_i = '0;
   logic [NR-1:0]    req_ready_o;
   logic [NR*DW-1:0] req_op1_i = '0;
   logic [NR*DW-1:0] req_op2_i = '0;
   logic [NR-1:0]    rsp_valid_o;
   logic [NR-1:0]    rsp_ready_i = '1;
   logic [DW-1:0]    rsp_result_o;
   logic             rsp_err_o;
   logic             mul_start_o;
   logic [DW-1:0]    mul_op1_o;
   logic [DW-1:0]    mul_op2_o;
   logic             mul_done_i;
   logic [DW-1:0]    mul_result_i;
   logic             busy_o;
   logic             stub_done = 1'b0;
   logic             force_done = 1'b0;
   logic [DW-1:0]    junk = '0;

   assign mul_done_i   = stub_done | force_done;
   assign mul_result_i = mul_done_i ? (mul_op1_o * mul_op2_o) : junk;

   si_mul_sched #(.REG_DW(DW), .NREQ(NR), .TIMEOUT(TO), .CNT_W(4)) dut (
      .clk(clk), .rst(rst),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o),
      .req_op1_i(req_op1_i), .req_op2_i(req_op2_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_err_o(rsp_err_o),
      .mul_start_o(mul_start_o), .mul_op1_o(mul_op1_o), .mul_op2_o(mul_op2_o),
      .mul_done_i(mul_done_i), .mul_result_i(mul_result_i),
      .busy_o(busy_o)
   );

   int n_cmp = 0;
   int n_bad = 0;
   int cyc   = 0;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // stimulus state
   logic [63:0] q0[$];
   logic [63:0] q1[$];
   int          lat_cfg  = 3;
   bit          lat_rand = 1'b0;
   int          rdy_mode = 0;
   bit          st_seen  = 1'b0;
   logic [NR-1:0] gnt_seen = '0;
   int          st_cnt   = 0;

   // model state and logs
   bit          m_busy = 0, m_resp = 0, m_err = 0;
   int          m_rr = 0, m_owner = 0, m_tacc = 0, m_trsp = 0;
   logic [DW-1:0] m_a = '0, m_b = '0, m_res = '0;
   int          lg_owner[$], lg_err[$], lg_lat[$], lg_hold[$], ac_owner[$];
   logic [DW-1:0] lg_res[$];

   // requesters, multiplier stub, response sink
   always @(posedge clk) begin
      logic [63:0] j;
      #1;
      junk = $urandom;
      case (rdy_mode)
         0:       rsp_ready_i = '1;
         1:       rsp_ready_i = NR'($urandom);
         default: rsp_ready_i = '0;
      endcase
      if (rst) begin
         st_cnt    = 0;
         stub_done = 1'b0;
      end else begin
         if (st_seen)
            st_cnt = lat_rand ? (($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(1, 5))) : lat_cfg;
         else if (st_cnt > 0)
            st_cnt = st_cnt - 1;
         stub_done = (st_cnt == 1);
      end
      if (gnt_seen[0]) req_valid_i[0] = 1'b0;
      if (gnt_seen[1]) req_valid_i[1] = 1'b0;
      if (!req_valid_i[0] && q0.size() > 0) begin
         j = q0.pop_front();
         req_op1_i[0 +: DW] = j[63:32];
         req_op2_i[0 +: DW] = j[31:0];
         req_valid_i[0] = 1'b1;
      end
      if (!req_valid_i[1] && q1.size() > 0) begin
         j = q1.pop_front();
         req_op1_i[DW +: DW] = j[63:32];
         req_op2_i[DW +: DW] = j[31:0];
         req_valid_i[1] = 1'b1;
      end
   end

   // model and per-cycle compare
   always @(negedge clk) begin
      logic [NR-1:0] exp_ready;
      int g;
      cyc++;
      st_seen  = mul_start_o && !rst;
      gnt_seen = rst ? '0 : (req_ready_o & req_valid_i);
      if (rst) begin
         chk("rst_ctrl", {req_ready_o, rsp_valid_o, rsp_err_o, mul_start_o, busy_o}, 0);
         chk("rst_result", rsp_result_o, 0);
         chk("rst_ops", {mul_op1_o, mul_op2_o}, 0);
         m_busy = 0; m_resp = 0; m_rr = 0;
      end else begin
         exp_ready = '0;
         g = -1;
         if (!m_busy)
            for (int i = 0; i < NR; i++)
               if (req_valid_i[(m_rr + i) % NR]) begin
                  g = (m_rr + i) % NR;
                  break;
               end
         if (g >= 0) exp_ready[g] = 1'b1;
         chk("req_ready", req_ready_o, exp_ready);
         chk("busy", busy_o, m_busy);
         chk("mul_start", mul_start_o, m_busy && !m_resp && cyc == m_tacc + 1);
         chk("rsp_valid", rsp_valid_o, m_resp ? (1 << m_owner) : 0);
         chk("rsp_result", rsp_result_o, m_resp ? m_res : 0);
         chk("rsp_err", rsp_err_o, m_resp ? m_err : 0);
         if (m_busy && !m_resp && cyc > m_tacc)
            chk("mul_ops", {mul_op1_o, mul_op2_o}, {m_a, m_b});
         if (!m_busy) begin
            if (g >= 0) begin
               m_busy = 1; m_resp = 0; m_owner = g; m_tacc = cyc;
               m_a = req_op1_i[g*DW +: DW];
               m_b = req_op2_i[g*DW +: DW];
               ac_owner.push_back(g);
            end
         end else if (!m_resp) begin
            if (cyc >= m_tacc + 2) begin
               if (mul_done_i) begin
                  m_resp = 1; m_res = m_a * m_b; m_err = 0; m_trsp = cyc + 1;
               end else if (cyc - (m_tacc + 2) == TO - 1) begin
                  m_resp = 1; m_res = '0; m_err = 1; m_trsp = cyc + 1;
               end
            end
         end else if (rsp_ready_i[m_owner]) begin
            lg_owner.push_back(m_owner);
            lg_res.push_back(m_res);
            lg_err.push_back(int'(m_err));
            lg_lat.push_back(m_trsp - m_tacc);
            lg_hold.push_back(cyc - m_trsp + 1);
            m_busy = 0; m_resp = 0;
            m_rr = (m_owner + 1) % NR;
         end
      end
   end

   task automatic wait_rsp(input int n);
      int t = 0;
      while (lg_owner.size() < n && t < 400) begin
         @(negedge clk);
         t++;
      end
      chk("wait_rsp", lg_owner.size(), n);
   endtask

   initial begin
      #500000;
      n_bad++;
      $display("FAIL global_timeout: got running expected finished");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

   initial begin
      int n, na, t;
      logic [31:0] a, b;
      repeat (3) @(posedge clk);
      #1 rst = 1'b0;

      lat_cfg = 3;
      q0.push_back({32'd7, 32'd6});
      wait_rsp(1);
      chk("t1_owner", lg_owner[0], 0);
      chk("t1_result", lg_res[0], 42);
      chk("t1_err", lg_err[0], 0);
      chk("t1_latency", lg_lat[0], 5);

      q1.push_back({32'd3, 32'd5});
      wait_rsp(2);
      chk("t2_result", lg_res[1], 15);

      q0.push_back({32'hFFFF_FFFF, 32'd2});
      q0.push_back({32'd10, 32'd10});
      q1.push_back({32'd12, 32'd12});
      wait_rsp(5);
      chk("rr_order0", lg_owner[2], 0);
      chk("rr_order1", lg_owner[3], 1);
      chk("rr_order2", lg_owner[4], 0);
      chk("wrap_result", lg_res[2], 32'hFFFF_FFFE);
      chk("rr_result1", lg_res[3], 144);
      chk("rr_result2", lg_res[4], 100);

      lat_cfg = 0;
      q1.push_back({32'd9, 32'd9});
      wait_rsp(6);
      chk("to_owner", lg_owner[5], 1);
      chk("to_err", lg_err[5], 1);
      chk("to_result", lg_res[5], 0);
      chk("to_latency", lg_lat[5], 17);
      lat_cfg = 2;
      q0.push_back({32'd4, 32'd5});
      wait_rsp(7);
      chk("after_to_result", lg_res[6], 20);
      chk("after_to_err", lg_err[6], 0);
      chk("after_to_latency", lg_lat[6], 4);

      lat_cfg = 15;
      q1.push_back({32'd6, 32'd7});
      wait_rsp(8);
      chk("tie_err", lg_err[7], 0);
      chk("tie_result", lg_res[7], 42);
      chk("tie_latency", lg_lat[7], 17);

      lat_cfg = 1;
      rdy_mode = 2;
      q0.push_back({32'd11, 32'd3});
      t = 0;
      while (rsp_valid_o == '0 && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("hold_rsp_seen", rsp_valid_o, 2'b01);
      q1.push_back({32'd2, 32'd2});
      repeat (10) @(negedge clk);
      rdy_mode = 0;
      wait_rsp(10);
      chk("hold_owner", lg_owner[8], 0);
      chk("hold_result", lg_res[8], 33);
      chk("hold_cycles", lg_hold[8] >= 11, 1);
      chk("hold_next_owner", lg_owner[9], 1);
      chk("hold_next_result", lg_res[9], 4);

      q0.push_back({32'd5, 32'd5});
      wait_rsp(11);
      lat_cfg = 0;
      q1.push_back({32'd8, 32'd8});
      repeat (6) @(negedge clk);
      n = lg_owner.size();
      @(posedge clk);
      #1 rst = 1'b1;
      @(posedge clk);
      #1 rst = 1'b0;
      repeat (2) @(posedge clk);
      #1 force_done = 1'b1;
      @(posedge clk);
      #1 force_done = 1'b0;
      repeat (6) @(negedge clk);
      chk("rst_no_rsp", lg_owner.size(), n);
      na = ac_owner.size();
      lat_cfg = 1;
      q0.push_back({32'd2, 32'd3});
      q1.push_back({32'd3, 32'd4});
      wait_rsp(n + 2);
      chk("rst_rr_first", ac_owner[na], 0);
      chk("rst_rr_second", ac_owner[na + 1], 1);
      chk("rst_after_res0", lg_res[n], 6);
      chk("rst_after_res1", lg_res[n + 1], 12);

      lat_rand = 1'b1;
      rdy_mode = 1;
      n = lg_owner.size();
      for (int k = 0; k < 40; k++) begin
         a = ($urandom_range(0, 3) == 0) ? 32'hFFFF_FFFF - $urandom_range(0, 9) : $urandom;
         b = ($urandom_range(0, 1) == 0) ? $urandom_range(0, 300) : $urandom;
         if ($urandom_range(0, 1) == 0) q0.push_back({a, b});
         else q1.push_back({a, b});
         t = 0;
         while (q0.size() + q1.size() > 2 && t < 2000) begin
            @(negedge clk);
            t++;
         end
      end
      t = 0;
      while ((q0.size() + q1.size() > 0 || req_valid_i != '0 || m_busy) && t < 3000) begin
         @(negedge clk);
         t++;
      end
      chk("random_drained", lg_owner.size(), n + 40);
      repeat (3) @(negedge clk);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end
endmodule
